// File: rtl/parity_check_arbiter.sv
// ---------------------------------------------------------------------------
// parity_check_arbiter
//
// Shares one parity-check datapath among NREQ requesters. A round-robin
// arbiter picks one valid requester while idle. Its word and parity bit are
// captured, checked in the following cycle, and the result is held on a single
// response channel, tagged with the requester index, until it is accepted.
//
// Optional feature (macro PARITY_ERR_CNT_EN): a saturating error counter with
// a synchronous clear. It adds parameter CNT_W and ports err_clr/err_count.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid            [NREQ]
//   req_ready  per-requester accept, one-hot or zero  [NREQ]
//   req_data   packed words, requester i at [i*DATA_W +: DATA_W]
//   req_parity per-requester received parity bit      [NREQ]
//   rsp_valid  check result valid
//   rsp_ready  downstream accepts the result
//   rsp_id     index of the requester owning the result
//   rsp_error  1 = parity mismatch
//   err_clr    (PARITY_ERR_CNT_EN) clear the error counter
//   err_count  (PARITY_ERR_CNT_EN) saturating count of erroring responses
// ---------------------------------------------------------------------------
module parity_check_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_W     = 32,
    parameter int ODD_PARITY = 0
`ifdef PARITY_ERR_CNT_EN
    ,
    parameter int CNT_W      = 8
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    input  logic [NREQ-1:0]           req_parity,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      rsp_error
`ifdef PARITY_ERR_CNT_EN
    ,
    input  logic                      err_clr,
    output logic [CNT_W-1:0]          err_count
`endif
);

    localparam int ID_W = $clog2(NREQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    // Odd parity flips the expected sense of the check
    localparam logic ODD_BIT_C = (ODD_PARITY != 0);

    // 1 when the data plus parity bit do not match the chosen parity scheme
    function automatic logic parity_mismatch(input logic [DATA_W-1:0] d, input logic p);
        parity_mismatch = (^d) ^ p ^ ODD_BIT_C;
    endfunction

    logic [1:0]        state_r;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [DATA_W-1:0] data_r;
    logic              parity_r;
    logic [ID_W-1:0]   id_r;
    logic              rsp_valid_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic              rsp_error_r;

    logic [ID_W-1:0]   winner_s;
    logic              grant_found_s;
    logic              accept_s;
    logic              rsp_hs_s;

    // Round-robin search: first valid requester after rr_ptr, wrapping modulo NREQ
    always_comb begin
        logic [ID_W:0] cand_s;
        grant_found_s = 1'b0;
        winner_s      = rr_ptr_r;
        cand_s        = {(ID_W+1){1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
            if (cand_s >= (ID_W+1)'(NREQ)) begin
                cand_s = cand_s - (ID_W+1)'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_found_s && req_valid[cand_s[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                winner_s      = cand_s[ID_W-1:0];
            end else begin
                winner_s      = winner_s;
            end
        end
    end

    // Grant is offered only while idle, so at most one ready bit is ever high
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if ((state_r == IDLE) && grant_found_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    assign accept_s = (state_r == IDLE) && grant_found_s;
    assign rsp_hs_s = (state_r == RESP) && rsp_ready;

    // Control FSM, capture registers and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= ID_W'(NREQ - 1);
            data_r      <= {DATA_W{1'b0}};
            parity_r    <= 1'b0;
            id_r        <= {ID_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_error_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        data_r   <= req_data[winner_s*DATA_W +: DATA_W];
                        parity_r <= req_parity[winner_s];
                        id_r     <= winner_s;
                        rr_ptr_r <= winner_s;
                        state_r  <= CHECK;
                    end
                end
                CHECK: begin
                    rsp_error_r <= parity_mismatch(data_r, parity_r);
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_error = rsp_error_r;

`ifdef PARITY_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    logic [CNT_W-1:0] err_count_r;

    // Saturating count of erroring responses; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= {CNT_W{1'b0}};
        end else if (err_clr) begin
            err_count_r <= {CNT_W{1'b0}};
        end else if (rsp_hs_s && rsp_error_r && (err_count_r != CNT_MAX_C)) begin
            err_count_r <= err_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign err_count = err_count_r;
`else
    // The handshake is consumed only by the optional error counter
    logic unused_hs_s;
    assign unused_hs_s = rsp_hs_s;
`endif

endmodule

// File: tb/tb_parity_check_arbiter.sv
// ---------------------------------------------------------------------------
// Directed bench for parity_check_arbiter (NREQ=4, DATA_W=32, even parity).
// Expected values are hand-computed from the parity definition and the
// round-robin rule. With PARITY_ERR_CNT_EN the counter runs with CNT_W=2.
// ---------------------------------------------------------------------------
module tb_parity_check_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [3:0]   req_parity;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic         rsp_error;
`ifdef PARITY_ERR_CNT_EN
    logic         err_clr;
    logic [1:0]   err_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    parity_check_arbiter #(
        .NREQ(4), .DATA_W(32), .ODD_PARITY(0)
`ifdef PARITY_ERR_CNT_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_parity(req_parity),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_error(rsp_error)
`ifdef PARITY_ERR_CNT_EN
        , .err_clr(err_clr), .err_count(err_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // Present one word on requester idx and follow it to its response
    task automatic send(input int idx, input logic [31:0] d, input logic p, input logic exp_err);
        logic [3:0] exp_rdy;
        int w;
        exp_rdy = 4'b0001 << idx;
        req_valid = 4'b0000;
        req_valid[idx] = 1'b1;
        req_data[idx*32 +: 32] = d;
        req_parity[idx] = p;
        rsp_ready = 1'b1;
        #1;
        w = 0;
        while (req_ready[idx] !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check_eq("grant", 64'(req_ready), 64'(exp_rdy));
        tick();                                   // T+1: word in CHECK
        req_valid = 4'b0000;
        req_data[idx*32 +: 32] = ~d;              // must not disturb captured word
        req_parity[idx] = ~p;
        check_eq("check_no_valid", 64'(rsp_valid), 64'd0);
        tick();                                   // T+2: result visible
        check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("rsp_id", 64'(rsp_id), 64'(idx));
        check_eq("rsp_error", 64'(rsp_error), 64'(exp_err));
        tick();                                   // handshake consumed
        check_eq("rsp_drop", 64'(rsp_valid), 64'd0);
    endtask

    task automatic wait_rsp(input string tag);
        int w;
        w = 0;
        while (rsp_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check_eq(tag, 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        int got[$];
        int exp_a[5];
        int exp_b[4];
        int w;
        req_data   = 128'd0;
        req_parity = 4'b0000;
`ifdef PARITY_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        #2;
        check_eq("rst_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_id", 64'(rsp_id), 64'd0);
        check_eq("rst_error", 64'(rsp_error), 64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        do_reset();

        // Single word, then the data sweep on requester 1
        send(0, 32'd0,   1'b1, 1'b1);
        send(0, 32'd128, 1'b1, 1'b0);
        send(1, 32'd254, 1'b1, 1'b0);
        send(1, 32'd439, 1'b0, 1'b1);
        send(1, 32'd369, 1'b1, 1'b0);
        send(1, 32'd711, 1'b0, 1'b0);

        // Round-robin with all requesters valid
        do_reset();
        req_data   = 128'd0;
        req_parity = 4'b0000;
        req_valid  = 4'b1111;
        rsp_ready  = 1'b1;
        exp_a = '{0, 1, 2, 3, 0};
        w = 0;
        while (got.size() < 5 && w < 40) begin
            tick();
            if (rsp_valid) got.push_back(int'(rsp_id));
            w++;
        end
        req_valid = 4'b1010;
        check_eq("rr_count", 64'(got.size()), 64'd5);
        for (int i = 0; i < got.size(); i++) check_eq("rr_all", 64'(got[i]), 64'(exp_a[i]));
        got.delete();
        exp_b = '{1, 3, 1, 3};
        w = 0;
        while (got.size() < 4 && w < 40) begin
            tick();
            if (rsp_valid) got.push_back(int'(rsp_id));
            w++;
        end
        req_valid = 4'b0000;
        check_eq("rr_alt_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size(); i++) check_eq("rr_alt", 64'(got[i]), 64'(exp_b[i]));
        tick();
        tick();

        // Backpressure on requester 2 (7 has three ones, even parity -> error)
        req_data[2*32 +: 32] = 32'd7;
        req_parity[2] = 1'b0;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        wait_rsp("bp_wait");
        req_data[3*32 +: 32] = 32'd1;
        req_parity[3] = 1'b0;
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", 64'(rsp_valid), 64'd1);
            check_eq("bp_id", 64'(rsp_id), 64'd2);
            check_eq("bp_error", 64'(rsp_error), 64'd1);
            check_eq("bp_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_resume", 64'(req_ready), 64'b1000);
        rsp_ready = 1'b0;
        tick();
        tick();
        check_eq("inflight_valid", 64'(rsp_valid), 64'd1);
        check_eq("inflight_err", 64'(rsp_error), 64'd1);

        // Reset while in RESP
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(rsp_valid), 64'd0);
        check_eq("midrst_id", 64'(rsp_id), 64'd0);
        check_eq("midrst_error", 64'(rsp_error), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check_eq("post_rst_grant", 64'(req_ready), 64'b0001);
        wait_rsp("post_rst_wait");
        check_eq("post_rst_id", 64'(rsp_id), 64'd0);
        req_valid = 4'b0000;
        tick();
        tick();

`ifdef PARITY_ERR_CNT_EN
        do_reset();
        check_eq("cnt_rst", 64'(err_count), 64'd0);
        send(0, 32'd0, 1'b1, 1'b1);
        check_eq("cnt_one", 64'(err_count), 64'd1);
        for (int i = 0; i < 4; i++) send(0, 32'd0, 1'b1, 1'b1);
        check_eq("cnt_sat", 64'(err_count), 64'd3);
        req_data[31:0] = 32'd0;
        req_parity[0] = 1'b1;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        wait_rsp("clr_wait");
        req_valid = 4'b0000;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("cnt_clr_prio", 64'(err_count), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
